// File: rtl/pipe_mul_load.sv
// pipe_mul_load: head of the dot-product pipeline.
// Collects MATRIX_DIM (a, b) element pairs over a valid/ready handshake,
// multiplies them lane-wise in signed fixed point with saturation, and
// presents the products as one registered vector with a one-cycle strobe.

module pipe_mul_load #(
    parameter int WORD_LEN   = 32,
    parameter int MATRIX_DIM = 8,
    parameter int FRAC_BITS  = 21
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_LEN-1:0]            in_a,
    input  logic [WORD_LEN-1:0]            in_b,
    output logic                           out_valid,
    output logic [WORD_LEN*MATRIX_DIM-1:0] Out_1,
    output logic                           out_sat,
    output logic [15:0]                    vec_count
);

    localparam int IDX_W = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_DIM - 1);

    // Saturation thresholds expressed at full product width.
    localparam logic signed [2*WORD_LEN-1:0] SAT_MAX =
        {{(WORD_LEN+1){1'b0}}, {(WORD_LEN-1){1'b1}}};
    localparam logic signed [2*WORD_LEN-1:0] SAT_MIN =
        {{(WORD_LEN+1){1'b1}}, {(WORD_LEN-1){1'b0}}};
    localparam logic [WORD_LEN-1:0] LANE_MAX = {1'b0, {(WORD_LEN-1){1'b1}}};
    localparam logic [WORD_LEN-1:0] LANE_MIN = {1'b1, {(WORD_LEN-1){1'b0}}};

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MUL  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_nextState;
    logic [IDX_W-1:0]               r_idx;
    logic                           w_xfer;
    logic [WORD_LEN-1:0]            r_a [MATRIX_DIM];
    logic [WORD_LEN-1:0]            r_b [MATRIX_DIM];
    logic [WORD_LEN*MATRIX_DIM-1:0] r_out;
    logic                           r_sat;
    logic [15:0]                    r_vecCount;

    logic signed [2*WORD_LEN-1:0]   w_prod [MATRIX_DIM];
    logic signed [2*WORD_LEN-1:0]   w_q    [MATRIX_DIM];
    logic [WORD_LEN*MATRIX_DIM-1:0] w_lanes;
    logic [MATRIX_DIM-1:0]          w_laneSat;

    // Next-state and handshake decode; in_ready/out_valid depend only on state.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                w_xfer   = in_valid;
                if (in_valid && (r_idx == LAST_IDX)) begin
                    w_nextState = MUL;
                end
            end
            MUL: begin
                w_nextState = EMIT;
            end
            EMIT: begin
                out_valid   = 1'b1;
                w_nextState = LOAD;
            end
            default: begin
                w_nextState = LOAD;
            end
        endcase
    end

    // State, load index, product vector and completed-vector counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD;
            r_idx      <= '0;
            r_out      <= '0;
            r_sat      <= 1'b0;
            r_vecCount <= 16'd0;
        end else begin
            r_state <= w_nextState;
            if (w_xfer) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (r_state == MUL) begin
                r_out <= w_lanes;
                r_sat <= |w_laneSat;
            end
            if (r_state == EMIT) begin
                r_vecCount <= r_vecCount + 16'd1;
            end
        end
    end

    // Operand buffers need no reset: every slot is rewritten before each MUL.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_a[r_idx] <= in_a;
            r_b[r_idx] <= in_b;
        end
    end

    // Lane-wise signed multiply, floor-shift to the fixed-point scale, clamp.
    always_comb begin
        w_lanes   = '0;
        w_laneSat = '0;
        for (int i = 0; i < MATRIX_DIM; i++) begin
            w_prod[i] = $signed(r_a[i]) * $signed(r_b[i]);
            w_q[i]    = w_prod[i] >>> FRAC_BITS;
            if (w_q[i] > SAT_MAX) begin
                w_lanes[i*WORD_LEN +: WORD_LEN] = LANE_MAX;
                w_laneSat[i]                    = 1'b1;
            end else if (w_q[i] < SAT_MIN) begin
                w_lanes[i*WORD_LEN +: WORD_LEN] = LANE_MIN;
                w_laneSat[i]                    = 1'b1;
            end else begin
                w_lanes[i*WORD_LEN +: WORD_LEN] = w_q[i][WORD_LEN-1:0];
            end
        end
    end

    assign Out_1     = r_out;
    assign out_sat   = r_sat;
    assign vec_count = r_vecCount;

endmodule

// File: tb/tb_pipe_mul_load.sv
// Testbench for pipe_mul_load: directed vectors with hand-computed lanes,
// handshake gaps, held-valid during MUL/EMIT, and reset mid-load.

module tb_pipe_mul_load;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_a;
    logic [31:0]  in_b;
    logic         out_valid;
    logic [255:0] Out_1;
    logic         out_sat;
    logic [15:0]  vec_count;

    int           testsRun    = 0;
    int           testsFailed = 0;
    int           pulseCount  = 0;
    int           expPulses   = 0;
    logic [31:0]  vecA    [8];
    logic [31:0]  vecB    [8];
    logic [31:0]  expLane [8];
    logic         expSat;
    logic [15:0]  expCount;

    pipe_mul_load #(
        .WORD_LEN   (32),
        .MATRIX_DIM (8),
        .FRAC_BITS  (21)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .Out_1     (Out_1),
        .out_sat   (out_sat),
        .vec_count (vec_count)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Count every strobe so spurious vectors are caught.
    always @(posedge clk) begin
        if (out_valid) pulseCount++;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Send the 8 pairs in vecA/vecB and check the MUL/EMIT/LOAD sequence.
    task automatic applyStimulus(input bit gaps, input bit holdValid);
        logic [255:0] expBus;
        int           g;
        int           guard;
        for (int i = 0; i < 8; i++) expBus[i*32 +: 32] = expLane[i];
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                g        = $urandom_range(0, 3);
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            in_valid = 1'b1;
            in_a     = vecA[i];
            in_b     = vecB[i];
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) checkOutput("ready_timeout", {255'd0, in_ready}, 256'd1);
            @(posedge clk);
            @(negedge clk);
        end
        if (holdValid) begin
            in_a = 32'hDEAD_BEEF;
            in_b = 32'h1234_5678;
        end else begin
            in_valid = 1'b0;
        end
        checkOutput("mul_ready", {255'd0, in_ready}, 256'd0);
        checkOutput("mul_valid", {255'd0, out_valid}, 256'd0);
        @(negedge clk);
        checkOutput("emit_valid", {255'd0, out_valid}, 256'd1);
        checkOutput("emit_ready", {255'd0, in_ready}, 256'd0);
        checkOutput("emit_lanes", Out_1, expBus);
        checkOutput("emit_sat", {255'd0, out_sat}, {255'd0, expSat});
        @(negedge clk);
        in_valid = 1'b0;
        expCount++;
        expPulses++;
        checkOutput("post_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("post_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("vec_count", {240'd0, vec_count}, {240'd0, expCount});
        checkOutput("lanes_hold", Out_1, expBus);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        expCount = 16'd0;

        #12;
        checkOutput("rst_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("rst_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("rst_out", Out_1, 256'd0);
        checkOutput("rst_sat", {255'd0, out_sat}, 256'd0);
        checkOutput("rst_count", {240'd0, vec_count}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] vector 1: 1.0 * 1.0");
        for (int i = 0; i < 8; i++) begin
            vecA[i] = 32'h0020_0000; vecB[i] = 32'h0020_0000; expLane[i] = 32'h0020_0000;
        end
        expSat = 1'b0;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] vector 2: 2.0 * -3.0");
        for (int i = 0; i < 8; i++) begin
            vecA[i] = 32'h0040_0000; vecB[i] = 32'hFFA0_0000; expLane[i] = 32'hFF40_0000;
        end
        expSat = 1'b0;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] vector 3: saturation");
        for (int i = 0; i < 8; i++) begin
            vecA[i] = 32'h1234_5678; vecB[i] = 32'h0000_0000; expLane[i] = 32'h0000_0000;
        end
        vecA[0] = 32'h4000_0000; vecB[0] = 32'h0080_0000; expLane[0] = 32'h7FFF_FFFF;
        vecA[1] = 32'h8000_0000; vecB[1] = 32'h0040_0000; expLane[1] = 32'h8000_0000;
        expSat = 1'b1;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] vector 4: truncation and range edges");
        vecA[0] = 32'h0000_0001; vecB[0] = 32'h0010_0000; expLane[0] = 32'h0000_0000;
        vecA[1] = 32'hFFFF_FFFF; vecB[1] = 32'h0010_0000; expLane[1] = 32'hFFFF_FFFF;
        vecA[2] = 32'h7FFF_FFFF; vecB[2] = 32'h0020_0000; expLane[2] = 32'h7FFF_FFFF;
        vecA[3] = 32'h8000_0000; vecB[3] = 32'h0020_0000; expLane[3] = 32'h8000_0000;
        for (int i = 4; i < 8; i++) begin
            vecA[i] = 32'h0030_0000; vecB[i] = 32'h0030_0000; expLane[i] = 32'h0048_0000;
        end
        expSat = 1'b0;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] vector 5: gaps and valid held through MUL/EMIT");
        vecB = '{default: 32'h0010_0000};
        vecA[0] = 32'h0020_0000; expLane[0] = 32'h0010_0000;
        vecA[1] = 32'h0040_0000; expLane[1] = 32'h0020_0000;
        vecA[2] = 32'h0060_0000; expLane[2] = 32'h0030_0000;
        vecA[3] = 32'h0080_0000; expLane[3] = 32'h0040_0000;
        vecA[4] = 32'h00A0_0000; expLane[4] = 32'h0050_0000;
        vecA[5] = 32'h00C0_0000; expLane[5] = 32'h0060_0000;
        vecA[6] = 32'h00E0_0000; expLane[6] = 32'h0070_0000;
        vecA[7] = 32'h0100_0000; expLane[7] = 32'h0080_0000;
        expSat = 1'b0;
        applyStimulus(1'b1, 1'b1);

        $display("[TB] vector 6: reset after 5 pairs");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h00A0_0000;
            in_b     = 32'h0020_0000;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expCount = 16'd0;
        checkOutput("mid_rst_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("mid_rst_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("mid_rst_out", Out_1, 256'd0);
        checkOutput("mid_rst_count", {240'd0, vec_count}, 256'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecA = '{default: 32'hFFE0_0000};
        vecB[0] = 32'h0020_0000; expLane[0] = 32'hFFE0_0000;
        vecB[1] = 32'h0040_0000; expLane[1] = 32'hFFC0_0000;
        vecB[2] = 32'h0060_0000; expLane[2] = 32'hFFA0_0000;
        vecB[3] = 32'h0080_0000; expLane[3] = 32'hFF80_0000;
        vecB[4] = 32'h00A0_0000; expLane[4] = 32'hFF60_0000;
        vecB[5] = 32'h00C0_0000; expLane[5] = 32'hFF40_0000;
        vecB[6] = 32'h00E0_0000; expLane[6] = 32'hFF20_0000;
        vecB[7] = 32'h0100_0000; expLane[7] = 32'hFF00_0000;
        expSat = 1'b0;
        applyStimulus(1'b0, 1'b0);

        repeat (4) @(negedge clk);
        checkOutput("pulse_count", 256'(pulseCount), 256'(expPulses));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
